// File: rtl/sudoku_pkg.sv
// Shared types and constants for the sudoku engine and its puzzle ROM.
package sudoku_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        PLAY = 2'd1,
        WON  = 2'd2,
        LOST = 2'd3
    } state_t;

    localparam int GRID_N    = 9;
    localparam int NUM_CELLS = 81;

    typedef logic [3:0] cell_t;

endpackage

// File: rtl/sudoku_puzzle_rom.sv
// Combinational puzzle/solution ROM. Every solution is a digit relabelling of
// one base grid built from row shifts (0,3,6,1,4,7,2,5,8). A cell is a given
// unless (row + 2*col + puzzle) is a multiple of 3, so about a third of the
// cells are left blank.
module sudoku_puzzle_rom
    import sudoku_pkg::*;
#(
    parameter int NUM_PUZZLES = 4
) (
    input  logic [1:0] selector,
    input  logic [3:0] row,
    input  logic [3:0] col,
    output cell_t      puzzle_val,
    output cell_t      solution_val
);

    int r_i;
    int c_i;
    int p_i;
    int base_i;

    // Derive the solution digit and whether this cell is shown as a given
    always_comb begin
        r_i          = int'(row);
        c_i          = int'(col);
        p_i          = int'(selector) % NUM_PUZZLES;
        base_i       = (r_i * 3 + r_i / 3 + c_i) % GRID_N;
        solution_val = 4'((base_i + p_i) % GRID_N + 1);
        puzzle_val   = 4'd0;
        if (((r_i + 2 * c_i + p_i) % 3) != 0) begin
            puzzle_val = solution_val;
        end
    end

endmodule

// File: rtl/sudoku_engine.sv
// Sudoku game engine: loads a ROM puzzle one cell per cycle, then lets the
// player move a wrapping cursor and write digits into non-given cells, and
// latches a win/lose result when checking is enabled.
module sudoku_engine
    import sudoku_pkg::*;
#(
    parameter int NUM_PUZZLES = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [1:0]                           puzzle_selector,
    input  logic [3:0]                           cmd_number,
    input  logic                                 cmd_up,
    input  logic                                 cmd_down,
    input  logic                                 cmd_left,
    input  logic                                 cmd_right,
    input  logic                                 cmd_enter,
    input  logic                                 cmd_valid,
    input  logic                                 check_enable,
    output logic [3:0]                           current_x,
    output logic [3:0]                           current_y,
    output logic [3:0]                           current_val,
    output logic                                 game_won,
    output logic                                 game_lost,
    output logic                                 engine_ready,
    output logic                                 check_win,
    output logic                                 check_lose,
    output logic [GRID_N-1:0][GRID_N-1:0]        cell_match,
    output logic [GRID_N-1:0][GRID_N-1:0][3:0]   grid_out,
    output logic [GRID_N-1:0][GRID_N-1:0]        fixed_mask_out
);

    state_t state;
    state_t next_state;

    logic [6:0] load_counter;
    logic [3:0] load_row;
    logic [3:0] load_col;
    cell_t      rom_puzzle;
    cell_t      rom_solution;

    logic [GRID_N-1:0][GRID_N-1:0][3:0] grid;
    logic [GRID_N-1:0][GRID_N-1:0][3:0] solution;
    logic [GRID_N-1:0][GRID_N-1:0]      fixed_mask;

    logic up_prev, down_prev, left_prev, right_prev, enter_prev;
    logic up_evt, down_evt, left_evt, right_evt, enter_evt;
    logic enter_ok;
    logic all_filled;

    assign load_row = 4'(load_counter / 7'd9);
    assign load_col = 4'(load_counter % 7'd9);

    sudoku_puzzle_rom #(
        .NUM_PUZZLES (NUM_PUZZLES)
    ) u_rom (
        .selector     (puzzle_selector),
        .row          (load_row),
        .col          (load_col),
        .puzzle_val   (rom_puzzle),
        .solution_val (rom_solution)
    );

    assign up_evt    = cmd_valid & cmd_up    & ~up_prev;
    assign down_evt  = cmd_valid & cmd_down  & ~down_prev;
    assign left_evt  = cmd_valid & cmd_left  & ~left_prev;
    assign right_evt = cmd_valid & cmd_right & ~right_prev;
    assign enter_evt = cmd_valid & cmd_enter & ~enter_prev;

    // Enter loses to any movement event and never touches givens or digits above 9
    assign enter_ok = enter_evt & ~up_evt & ~down_evt & ~left_evt & ~right_evt
                      & ~fixed_mask[current_y][current_x] & (cmd_number <= 4'd9);

    // Remember raw button levels so a held button yields a single event
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_prev    <= 1'b0;
            down_prev  <= 1'b0;
            left_prev  <= 1'b0;
            right_prev <= 1'b0;
            enter_prev <= 1'b0;
        end else begin
            up_prev    <= cmd_up;
            down_prev  <= cmd_down;
            left_prev  <= cmd_left;
            right_prev <= cmd_right;
            enter_prev <= cmd_enter;
        end
    end

    // Game state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    // Next state: finish loading after the last cell, latch the result on check
    always_comb begin
        next_state = state;
        case (state)
            LOAD: begin
                if (load_counter == 7'(NUM_CELLS - 1)) begin
                    next_state = PLAY;
                end
            end
            PLAY: begin
                if (check_enable) begin
                    if (check_win) begin
                        next_state = WON;
                    end else if (check_lose) begin
                        next_state = LOST;
                    end
                end
            end
            default: next_state = state;
        endcase
    end

    // Walk the load address through all 81 cells
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_counter <= 7'd0;
        end else if (state == LOAD) begin
            load_counter <= load_counter + 7'd1;
        end
    end

    // Board storage: filled from the ROM in LOAD, edited by enter in PLAY
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grid       <= '0;
            solution   <= '0;
            fixed_mask <= '0;
        end else if (state == LOAD) begin
            grid[load_row][load_col]       <= rom_puzzle;
            solution[load_row][load_col]   <= rom_solution;
            fixed_mask[load_row][load_col] <= (rom_puzzle != 4'd0);
        end else if ((state == PLAY) && enter_ok) begin
            grid[current_y][current_x] <= cmd_number;
        end
    end

    // Cursor moves with priority up > down > left > right, wrapping at the edges
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            current_x <= 4'd0;
            current_y <= 4'd0;
        end else if (state == PLAY) begin
            if (up_evt) begin
                current_y <= (current_y == 4'd0) ? 4'd8 : current_y - 4'd1;
            end else if (down_evt) begin
                current_y <= (current_y == 4'd8) ? 4'd0 : current_y + 4'd1;
            end else if (left_evt) begin
                current_x <= (current_x == 4'd0) ? 4'd8 : current_x - 4'd1;
            end else if (right_evt) begin
                current_x <= (current_x == 4'd8) ? 4'd0 : current_x + 4'd1;
            end
        end
    end

    // Per-cell match against the solution and whether the board is full
    always_comb begin
        cell_match = '0;
        all_filled = 1'b1;
        for (int r = 0; r < GRID_N; r++) begin
            for (int c = 0; c < GRID_N; c++) begin
                cell_match[r][c] = (grid[r][c] == solution[r][c]);
                if (grid[r][c] == 4'd0) begin
                    all_filled = 1'b0;
                end
            end
        end
    end

    assign check_win      = &cell_match;
    assign check_lose     = all_filled & ~check_win;
    assign current_val    = grid[current_y][current_x];
    assign grid_out       = grid;
    assign fixed_mask_out = fixed_mask;
    assign engine_ready   = (state == PLAY);
    assign game_won       = (state == WON);
    assign game_lost      = (state == LOST);

endmodule

// File: tb/tb_sudoku_engine.sv
// Scoreboard bench for sudoku_engine: every command pushes the cursor/value
// the bench model predicts, and the sampled DUT view is popped against it.
module tb_sudoku_engine;

    logic clk;
    logic reset;
    logic [1:0] puzzle_selector;
    logic [3:0] cmd_number;
    logic cmd_up, cmd_down, cmd_left, cmd_right, cmd_enter, cmd_valid;
    logic check_enable;
    logic [3:0] current_x, current_y, current_val;
    logic game_won, game_lost, engine_ready, check_win, check_lose;
    logic [8:0][8:0] cell_match;
    logic [8:0][8:0][3:0] grid_out;
    logic [8:0][8:0] fixed_mask_out;

    sudoku_engine #(.NUM_PUZZLES(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .puzzle_selector (puzzle_selector),
        .cmd_number      (cmd_number),
        .cmd_up          (cmd_up),
        .cmd_down        (cmd_down),
        .cmd_left        (cmd_left),
        .cmd_right       (cmd_right),
        .cmd_enter       (cmd_enter),
        .cmd_valid       (cmd_valid),
        .check_enable    (check_enable),
        .current_x       (current_x),
        .current_y       (current_y),
        .current_val     (current_val),
        .game_won        (game_won),
        .game_lost       (game_lost),
        .engine_ready    (engine_ready),
        .check_win       (check_win),
        .check_lose      (check_lose),
        .cell_match      (cell_match),
        .grid_out        (grid_out),
        .fixed_mask_out  (fixed_mask_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int val;
    } view_t;

    view_t exp_q[$];
    view_t obs_q[$];

    int checks   = 0;
    int failures = 0;

    int mx;
    int my;
    int msel;
    int mgrid[9][9];
    bit mplay;

    // Reference puzzle data: row shift table, relabelled per puzzle
    function automatic int sol_of(input int p, input int r, input int c);
        int shift[9];
        shift = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
        return (c + shift[r] + p) % 9 + 1;
    endfunction

    function automatic bit given_of(input int p, input int r, input int c);
        return ((r + 2 * c + p) % 3) != 0;
    endfunction

    task automatic model_load(input int p);
        msel = p;
        mx   = 0;
        my   = 0;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                mgrid[r][c] = given_of(p, r, c) ? sol_of(p, r, c) : 0;
    endtask

    // Drive one command for 'hold' cycles, predict the result, sample the DUT
    task automatic press(input bit u, input bit d, input bit l, input bit r,
                         input bit e, input int num, input int hold);
        @(negedge clk);
        cmd_up = u; cmd_down = d; cmd_left = l; cmd_right = r; cmd_enter = e;
        cmd_number = 4'(num);
        cmd_valid  = 1'b1;
        if (mplay) begin
            if (u)      my = (my + 8) % 9;
            else if (d) my = (my + 1) % 9;
            else if (l) mx = (mx + 8) % 9;
            else if (r) mx = (mx + 1) % 9;
            else if (e && !given_of(msel, my, mx) && num <= 9) mgrid[my][mx] = num;
        end
        exp_q.push_back('{mx, my, mgrid[my][mx]});
        repeat (hold - 1) @(negedge clk);
        @(negedge clk);
        cmd_up = 0; cmd_down = 0; cmd_left = 0; cmd_right = 0; cmd_enter = 0;
        cmd_valid = 1'b0;
        obs_q.push_back('{int'(current_x), int'(current_y), int'(current_val)});
    endtask

    task automatic goto_cell(input int tx, input int ty);
        while (mx != tx) press(0, 0, 0, 1, 0, 0, 1);
        while (my != ty) press(0, 1, 0, 0, 0, 0, 1);
    endtask

    // Release reset, count edges to ready, then compare the loaded board
    task automatic test_load(input int p);
        puzzle_selector = 2'(p);
        @(negedge clk);
        reset = 1'b1;
        for (int e = 1; e <= 81; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (engine_ready !== (e == 81)) begin
                failures++;
                $display("[TB] FAIL load_ready edge=%0d actual=%b required=%b", e, engine_ready, (e == 81));
            end
        end
        model_load(p);
        mplay = 1'b1;
        checks++;
        if (current_x !== 4'd0 || current_y !== 4'd0 || game_won !== 1'b0 || game_lost !== 1'b0) begin
            failures++;
            $display("[TB] FAIL load_status actual x=%0d y=%0d won=%b lost=%b required 0 0 0 0",
                     current_x, current_y, game_won, game_lost);
        end
        for (int r = 0; r < 9; r++) begin
            for (int c = 0; c < 9; c++) begin
                checks++;
                if (grid_out[r][c] !== 4'(mgrid[r][c]) || fixed_mask_out[r][c] !== given_of(p, r, c)) begin
                    failures++;
                    $display("[TB] FAIL load_cell r=%0d c=%0d actual val=%0d fixed=%b required val=%0d fixed=%b",
                             r, c, grid_out[r][c], fixed_mask_out[r][c], mgrid[r][c], given_of(p, r, c));
                end
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        puzzle_selector = 2'd0;
        cmd_number = 4'd0;
        cmd_up = 0; cmd_down = 0; cmd_left = 0; cmd_right = 0; cmd_enter = 0;
        cmd_valid = 0;
        check_enable = 0;
        mplay = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (engine_ready !== 1'b0 || game_won !== 1'b0 || game_lost !== 1'b0 ||
            current_x !== 4'd0 || current_y !== 4'd0 || grid_out !== '0 || fixed_mask_out !== '0) begin
            failures++;
            $display("[TB] FAIL reset_state actual ready=%b won=%b lost=%b x=%0d y=%0d required all zero",
                     engine_ready, game_won, game_lost, current_x, current_y);
        end
        // Abort a load partway and confirm the board clears at once
        reset = 1'b1;
        repeat (40) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (grid_out !== '0 || engine_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_abort actual ready=%b grid_nonzero=%b required ready=0 grid_nonzero=0",
                     engine_ready, (grid_out != '0));
        end
        test_load(0);
    endtask

    task automatic test_move;
        view_t e, o;
        press(1, 0, 0, 0, 0, 0, 1);
        press(0, 0, 0, 1, 0, 0, 5);
        for (int i = 0; i < 9; i++) press(0, 1, 0, 0, 0, 0, 1);
        press(0, 0, 1, 0, 0, 0, 1);
        press(0, 0, 1, 0, 0, 0, 1);
        press(0, 0, 0, 1, 0, 0, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o != e) begin
                failures++;
                $display("[TB] FAIL move actual x=%0d y=%0d val=%0d required x=%0d y=%0d val=%0d",
                         o.x, o.y, o.val, e.x, e.y, e.val);
            end
        end
    endtask

    task automatic test_priority;
        view_t e, o;
        press(1, 0, 0, 1, 0, 0, 1);
        press(0, 1, 1, 1, 1, 7, 1);
        press(0, 0, 1, 1, 0, 0, 1);
        press(0, 0, 0, 1, 1, 7, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o != e) begin
                failures++;
                $display("[TB] FAIL priority actual x=%0d y=%0d val=%0d required x=%0d y=%0d val=%0d",
                         o.x, o.y, o.val, e.x, e.y, e.val);
            end
        end
    endtask

    task automatic test_enter;
        view_t e, o;
        goto_cell(1, 0);
        press(0, 0, 0, 0, 1, 5, 1);
        goto_cell(0, 0);
        press(0, 0, 0, 0, 1, 5, 1);
        press(0, 0, 0, 0, 1, 12, 1);
        press(0, 0, 0, 0, 1, 0, 1);
        press(0, 0, 0, 0, 1, 3, 3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o != e) begin
                failures++;
                $display("[TB] FAIL enter actual x=%0d y=%0d val=%0d required x=%0d y=%0d val=%0d",
                         o.x, o.y, o.val, e.x, e.y, e.val);
            end
        end
    endtask

    task automatic test_win;
        view_t e, o;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                if (!given_of(msel, r, c)) begin
                    goto_cell(c, r);
                    press(0, 0, 0, 0, 1, sol_of(msel, r, c), 1);
                end
        checks++;
        if (check_win !== 1'b1 || check_lose !== 1'b0 || cell_match !== '1 || game_won !== 1'b0) begin
            failures++;
            $display("[TB] FAIL win_status actual win=%b lose=%b won=%b required win=1 lose=0 won=0",
                     check_win, check_lose, game_won);
        end
        @(negedge clk);
        check_enable = 1'b1;
        @(negedge clk);
        check_enable = 1'b0;
        mplay = 1'b0;
        checks++;
        if (game_won !== 1'b1 || game_lost !== 1'b0 || engine_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL win_latch actual won=%b lost=%b ready=%b required 1 0 0",
                     game_won, game_lost, engine_ready);
        end
        press(1, 0, 0, 0, 0, 0, 1);
        press(0, 0, 0, 1, 0, 0, 1);
        press(0, 0, 0, 0, 1, 0, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o != e) begin
                failures++;
                $display("[TB] FAIL win_frozen actual x=%0d y=%0d val=%0d required x=%0d y=%0d val=%0d",
                         o.x, o.y, o.val, e.x, e.y, e.val);
            end
        end
    endtask

    task automatic test_lose;
        view_t e, o;
        @(negedge clk);
        reset = 1'b0;
        mplay = 1'b0;
        test_load(2);
        puzzle_selector = 2'd3;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                if (!given_of(msel, r, c)) begin
                    goto_cell(c, r);
                    press(0, 0, 0, 0, 1, sol_of(msel, r, c) % 9 + 1, 1);
                end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o != e) begin
                failures++;
                $display("[TB] FAIL lose_fill actual x=%0d y=%0d val=%0d required x=%0d y=%0d val=%0d",
                         o.x, o.y, o.val, e.x, e.y, e.val);
            end
        end
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++) begin
                checks++;
                if (grid_out[r][c] !== 4'(mgrid[r][c])) begin
                    failures++;
                    $display("[TB] FAIL lose_grid r=%0d c=%0d actual=%0d required=%0d",
                             r, c, grid_out[r][c], mgrid[r][c]);
                end
            end
        checks++;
        if (check_lose !== 1'b1 || check_win !== 1'b0) begin
            failures++;
            $display("[TB] FAIL lose_status actual lose=%b win=%b required lose=1 win=0", check_lose, check_win);
        end
        @(negedge clk);
        check_enable = 1'b1;
        @(negedge clk);
        check_enable = 1'b0;
        checks++;
        if (game_lost !== 1'b1 || game_won !== 1'b0 || engine_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL lose_latch actual lost=%b won=%b ready=%b required 1 0 0",
                     game_lost, game_won, engine_ready);
        end
        reset = 1'b0;
        mplay = 1'b0;
        #1;
        checks++;
        if (engine_ready !== 1'b0 || game_lost !== 1'b0 || current_x !== 4'd0 || current_y !== 4'd0) begin
            failures++;
            $display("[TB] FAIL lose_reset actual ready=%b lost=%b x=%0d y=%0d required 0 0 0 0",
                     engine_ready, game_lost, current_x, current_y);
        end
        test_load(0);
    endtask

    initial begin
        test_reset();
        test_move();
        test_priority();
        test_enter();
        test_win();
        test_lose();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
